// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and a constant clog2 helper.
package uart_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_START_BIT,
    S_SEND_DATA,
    S_STOP_BIT
  } state_t;

  localparam int LP_BIT_TIME      = 16;
  localparam int LP_NUM_DATA_BITS = 8;
  localparam int LP_NUM_STOP_BITS = 2;
  localparam int LP_FRAME_TICKS   = LP_BIT_TIME * (1 + LP_NUM_DATA_BITS + LP_NUM_STOP_BITS);

  function automatic int clog2(input int value);
    int          r;
    int unsigned v;
    r = 0;
    v = (value > 0) ? int'(value - 1) : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-side handshake of the UART transmitter. A byte moves on any CLK edge where
// send && ready; Di is sampled only on that edge, and send while ready=0 is simply ignored.
interface uart_tx_if;
  logic [7:0] Di;
  logic       send;
  logic       ready;
  logic       busy;

  modport master (output Di, output send, input ready, input busy);
  modport slave  (input Di, input send, output ready, output busy);
endinterface

// File: rtl/uart_tx_hold.sv
// Holding register, hold_valid flag and ready generation for uart_tx.
// UART_TX_HOLD_REG_EN: double-buffered (accept during a frame); otherwise only from S_IDLE.
module uart_tx_hold
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] data,
  input  logic       load,
  input  state_t     state,
  output logic       ready,
  output logic       hold_valid,
  output logic [7:0] hold_data
);

`ifdef UART_TX_HOLD_REG_EN
  assign ready = ~hold_valid && (state != S_INIT);
`else
  assign ready = (state == S_IDLE) && ~hold_valid;
`endif

  // Accept and load can never coincide: accept needs hold_valid=0, load needs hold_valid=1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (send && ready) begin
      hold_valid <= 1'b1;
      hold_data  <= data;
    end else if (load) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: idle-high line, start bit, 8 data bits LSB first, two stop bits, 16 x16_BAUD
// ticks per bit, with a post-reset idle guard. UART_TX_HOLD_REG_EN selects double buffering.
module uart_tx
  import uart_pkg::*;
#(
  parameter int P_IDLE_TH = 176
) (
  input  logic     CLK,
  input  logic     reset,
  input  logic     x16_BAUD,
  uart_tx_if.slave bus,
  output logic     serial_out,
  output state_t   dbg_state
);

  localparam int                   LP_INIT_W    = (clog2(P_IDLE_TH) < 1) ? 1 : clog2(P_IDLE_TH);
  localparam logic [LP_INIT_W-1:0] LP_INIT_LAST = LP_INIT_W'(P_IDLE_TH - 1);
  localparam logic [4:0]           LP_BIT_LAST  = 5'(LP_BIT_TIME - 1);
  localparam logic [4:0]           LP_STOP_LAST = 5'(LP_BIT_TIME * LP_NUM_STOP_BITS - 1);
  localparam logic [2:0]           LP_DATA_LAST = 3'(LP_NUM_DATA_BITS - 1);

  state_t               state, state_next;
  logic [LP_INIT_W-1:0] init_cnt, init_next;
  logic [4:0]           tick_cnt, tick_next;
  logic [2:0]           bit_cnt, bit_next;
  logic [7:0]           shift, shift_next;
  logic                 line_next;
  logic                 load;
  logic                 hold_valid;
  logic [7:0]           hold_data;

  uart_tx_hold u_hold (
    .clk       (CLK),
    .rst       (reset),
    .send      (bus.send),
    .data      (bus.Di),
    .load      (load),
    .state     (state),
    .ready     (bus.ready),
    .hold_valid(hold_valid),
    .hold_data (hold_data)
  );

  assign bus.busy  = ((state != S_INIT) && (state != S_IDLE)) || hold_valid;
  assign dbg_state = state;

  // The line is registered from the next state, so it changes one CLK after the deciding tick.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= S_INIT;
      init_cnt   <= '0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      serial_out <= 1'b1;
    end else begin
      state      <= state_next;
      init_cnt   <= init_next;
      tick_cnt   <= tick_next;
      bit_cnt    <= bit_next;
      shift      <= shift_next;
      serial_out <= line_next;
    end
  end

  always_comb begin
    state_next = state;
    init_next  = init_cnt;
    tick_next  = tick_cnt;
    bit_next   = bit_cnt;
    shift_next = shift;
    load       = 1'b0;
    if (x16_BAUD) begin
      case (state)
        S_INIT: begin
          if (init_cnt == LP_INIT_LAST) begin
            init_next  = '0;
            state_next = S_IDLE;
          end else begin
            init_next = init_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (hold_valid) begin
            load       = 1'b1;
            shift_next = hold_data;
            tick_next  = '0;
            state_next = S_START_BIT;
          end
        end
        S_START_BIT: begin
          if (tick_cnt == LP_BIT_LAST) begin
            tick_next  = '0;
            bit_next   = '0;
            state_next = S_SEND_DATA;
          end else begin
            tick_next = tick_cnt + 5'd1;
          end
        end
        S_SEND_DATA: begin
          if (tick_cnt == LP_BIT_LAST) begin
            tick_next  = '0;
            shift_next = {1'b0, shift[7:1]};
            if (bit_cnt == LP_DATA_LAST) begin
              bit_next   = '0;
              state_next = S_STOP_BIT;
            end else begin
              bit_next = bit_cnt + 3'd1;
            end
          end else begin
            tick_next = tick_cnt + 5'd1;
          end
        end
        S_STOP_BIT: begin
          // A pending byte chains straight into the next start bit with no idle gap.
          if (tick_cnt == LP_STOP_LAST) begin
            tick_next = '0;
            if (hold_valid) begin
              load       = 1'b1;
              shift_next = hold_data;
              state_next = S_START_BIT;
            end else begin
              state_next = S_IDLE;
            end
          end else begin
            tick_next = tick_cnt + 5'd1;
          end
        end
        default: state_next = S_INIT;
      endcase
    end
  end

  always_comb begin
    line_next = 1'b1;
    case (state_next)
      S_START_BIT: line_next = 1'b0;
      S_SEND_DATA: line_next = shift_next[0];
      default:     line_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level reference model (list of frame start ticks and bytes) plus a
// line receiver with an expected-byte queue; directed table, corner sequences and random traffic.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int IDLE_TH = 176;
  localparam int BIT_T   = 16;
  localparam int FRAME_T = 176;
`ifdef UART_TX_HOLD_REG_EN
  localparam bit DOUBLE_BUF = 1'b1;
`else
  localparam bit DOUBLE_BUF = 1'b0;
`endif

  typedef struct {
    int         start;
    logic [7:0] data;
  } frame_t;

  typedef struct {
    logic [7:0]  di;
    int          gap;
    logic [10:0] exp_frame;
  } vec_t;

  logic   CLK      = 1'b0;
  logic   reset    = 1'b1;
  logic   x16_BAUD = 1'b0;
  logic   serial_out;
  state_t dbg_state;

  uart_tx_if bus ();

  uart_tx #(.P_IDLE_TH(IDLE_TH)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .x16_BAUD  (x16_BAUD),
    .bus       (bus),
    .serial_out(serial_out),
    .dbg_state (dbg_state)
  );

  always #5 CLK = ~CLK;

  int          n_vec = 0;
  int          n_miss = 0;
  int          ticks = 0;
  int          acc_tick = -1;
  frame_t      frames[$];
  logic [7:0]  exp_q[$];
  int          rx_starts[$];
  bit          rx_active = 1'b0;
  int          rx_cnt = 0;
  logic        rx_prev = 1'b1;
  logic [10:0] rx_frame = '1;
  logic [10:0] last_frame = '0;
  vec_t        vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h (tick %0d, t=%0t)", name, act, exp, ticks, $time);
    end
  endtask

  // ---------------- reference model: frames as (start tick, byte) ----------------
  function automatic int last_end();
    return (frames.size() > 0) ? frames[$].start + FRAME_T : 0;
  endfunction

  function automatic bit m_pending();
    return (frames.size() > 0) && (frames[$].start > ticks);
  endfunction

  function automatic bit m_active();
    foreach (frames[i])
      if (ticks >= frames[i].start && ticks < frames[i].start + FRAME_T) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready();
    if (DOUBLE_BUF) return (ticks >= IDLE_TH) && !m_pending();
    return (ticks >= IDLE_TH) && !m_pending() && (ticks >= last_end());
  endfunction

  function automatic bit m_busy();
    return m_pending() || m_active();
  endfunction

  function automatic logic m_line();
    int idx;
    foreach (frames[i]) begin
      if (ticks >= frames[i].start && ticks < frames[i].start + FRAME_T) begin
        idx = (ticks - frames[i].start) / BIT_T;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return frames[i].data[idx-1];
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    ticks     = 0;
    acc_tick  = -1;
    frames.delete();
    exp_q.delete();
    rx_starts.delete();
    rx_active = 1'b0;
    rx_cnt    = 0;
    rx_prev   = 1'b1;
  endtask

  // ---------------- receiver: mid-bit sampling on tick boundaries ----------------
  task automatic rx_done();
    logic [7:0] e;
    last_frame = rx_frame;
    check("rx_start_bit", rx_frame[0], 1'b0);
    check("rx_stop_bits", rx_frame[10:9], 2'b11);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL rx_Do: got Do=%h with valid, required no frame", rx_frame[8:1]);
    end else begin
      e = exp_q.pop_front();
      check("rx_Do", rx_frame[8:1], e);
    end
  endtask

  task automatic rx_sample(input logic s);
    if (!rx_active) begin
      if (rx_prev && !s) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
        rx_frame  = '1;
        rx_starts.push_back(ticks);
      end
    end else begin
      rx_cnt++;
    end
    if (rx_active && (rx_cnt % BIT_T) == 8) rx_frame[rx_cnt/BIT_T] = s;
    if (rx_active && rx_cnt == FRAME_T - 1) begin
      rx_active = 1'b0;
      rx_done();
    end
    rx_prev = s;
  endtask

  // ---------------- drivers ----------------
  // One CLK cycle, entered and left at a negedge; inputs change here, outputs are checked here.
  task automatic step(input bit is_tick);
    bit     acc;
    frame_t f;
    acc      = bus.send && m_ready();
    x16_BAUD = is_tick;
    @(negedge CLK);
    x16_BAUD = 1'b0;
    if (is_tick) begin
      ticks++;
      rx_sample(serial_out);
    end
    if (acc) begin
      f.start = (ticks + 1 > last_end()) ? ticks + 1 : last_end();
      f.data  = bus.Di;
      frames.push_back(f);
      exp_q.push_back(bus.Di);
      acc_tick = ticks;
      bus.send = 1'b0;
    end
    check("ready", bus.ready, m_ready());
    check("busy", bus.busy, m_busy());
    check("serial_out", serial_out, m_line());
  endtask

  task automatic tick(input int gap);
    repeat (3 + gap) step(1'b0);
    step(1'b1);
  endtask

  function automatic int rgap();
    return ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 40)) : 0;
  endfunction

  task automatic push_send(input logic [7:0] b, input int budget, input bit rnd);
    int n;
    n        = 0;
    bus.Di   = b;
    bus.send = 1'b1;
    while (bus.send && n < budget) begin
      tick(rnd ? rgap() : 0);
      n++;
    end
    check("send_accepted_in_budget", bus.send, 1'b0);
    bus.send = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input int gap_at, input int gap);
    int n;
    n = 0;
    while ((m_busy() || rx_active) && n < budget) begin
      tick((rx_active && rx_cnt == gap_at) ? gap : 0);
      n++;
    end
    check("idle_in_budget", m_busy() || rx_active, 1'b0);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    #1;
    check("reset_line_async", serial_out, 1'b1);
    model_reset();
    repeat (cycles) step(1'b0);
    check("reset_state", dbg_state, S_INIT);
    reset = 1'b0;
  endtask

  initial begin
    int t0;
    int s1;
    int n;
    vecs[0] = '{8'hA5, 0,  11'b11_10100101_0};
    vecs[1] = '{8'h5A, 50, 11'b11_01011010_0};
    vecs[2] = '{8'h00, 0,  11'b11_00000000_0};
    vecs[3] = '{8'hFF, 7,  11'b11_11111111_0};
    vecs[4] = '{8'h80, 0,  11'b11_10000000_0};

    bus.Di   = '0;
    bus.send = 1'b0;
    @(negedge CLK);
    do_reset(3);

    // Idle guard: send raised the moment reset drops; ready stays low for 176 ticks.
    push_send(8'h00, 400, 1'b0);
    check("guard_accept_tick", acc_tick, IDLE_TH);
    wait_idle(400, -1, 0);
    check("guard_first_start", (rx_starts.size() > 0) ? rx_starts[0] : -1, IDLE_TH + 1);

    // Directed frames, one with a 50-CLK enable gap inside data bit 1.
    for (int i = 0; i < 5; i++) begin
      repeat (2) tick(0);
      push_send(vecs[i].di, 400, 1'b0);
      wait_idle(400, 40, vecs[i].gap);
      check($sformatf("frame_%0d", i), last_frame, vecs[i].exp_frame);
    end

    // Back-to-back: second byte offered 20 ticks into the first frame.
    push_send(8'h3C, 400, 1'b0);
    repeat (20) tick(0);
    s1 = (rx_starts.size() > 0) ? rx_starts[$] : -1;
    t0 = ticks;
    push_send(8'hC3, 400, 1'b0);
    check("b2b_accept_tick", acc_tick, DOUBLE_BUF ? t0 : s1 + FRAME_T);
    wait_idle(800, -1, 0);
    check("b2b_start_spacing", (rx_starts.size() >= 2) ? rx_starts[$] - rx_starts[$-1] : -1,
          DOUBLE_BUF ? FRAME_T : FRAME_T + 1);

    // Random bytes at random offsets, with sporadic enable gaps.
    for (int i = 0; i < 8; i++) begin
      n = $urandom_range(0, 200);
      for (int k = 0; k < n; k++) tick(rgap());
      push_send(8'($urandom_range(0, 255)), 800, 1'b1);
    end
    wait_idle(800, -1, 0);

    // Reset in the middle of data bit 3 of 8'hFF: frame lost, guard restarts.
    repeat (3) tick(0);
    push_send(8'hFF, 400, 1'b0);
    n = 0;
    while (!(rx_active && rx_cnt == 70) && n < 400) begin
      tick(0);
      n++;
    end
    check("reached_data_bit3", rx_active && rx_cnt == 70, 1'b1);
    do_reset(2);
    push_send(8'h81, 400, 1'b0);
    check("post_reset_accept_tick", acc_tick, IDLE_TH);
    wait_idle(400, -1, 0);
    check("post_reset_frame", last_frame, 11'b11_10000001_0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at tick %0d", ticks);
    $fatal(1);
  end

endmodule
